apb_master_ctrl: RTL and testbench

APB master sequencer that accepts single read/write commands from an internal requester and runs the APB IDLE/SETUP/ACCESS protocol. It sits directly upstream of the 3-to-8 slave-select decoder and drives that decoder's 3-bit binary input and enable. The decoder's one-hot output forms the PSELx lines. The block also drives the shared APB address, data and control signals, and returns one response per command, including slave-error and timeout status.

---
 rtl/apb_master_ctrl.sv | 117 +++++++++++
 tb/tb_apb_master_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB master sequencer: runs single read/write commands through IDLE/SETUP/ACCESS,
// drives the slave-select decoder inputs and returns one response per command.
module apb_master_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  rsp_timeout,
    output logic [2:0]            sel_index,
    output logic                  sel_enable,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Last wait-counter value before an abort; unused when TIMEOUT is 0.
    localparam logic [15:0] WAIT_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      state_r;
    logic [15:0] wait_cnt_r;

    // Command acceptance is only possible while idle.
    assign cmd_ready = (state_r == ST_IDLE);

    // Transfer sequencer; sel_enable/PENABLE are loaded from the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 16'd0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            sel_index   <= 3'd0;
            sel_enable  <= 1'b0;
            PADDR       <= '0;
            PWRITE      <= 1'b0;
            PWDATA      <= '0;
            PENABLE     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        PADDR      <= cmd_addr;
                        PWRITE     <= cmd_write;
                        PWDATA     <= cmd_wdata;
                        sel_index  <= cmd_addr[ADDR_WIDTH-1 -: 3];
                        wait_cnt_r <= 16'd0;
                        sel_enable <= 1'b1;
                        PENABLE    <= 1'b0;
                        state_r    <= ST_SETUP;
                    end else begin
                        sel_enable <= 1'b0;
                        PENABLE    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    sel_enable <= 1'b1;
                    PENABLE    <= 1'b1;
                    state_r    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_error   <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        sel_enable  <= 1'b0;
                        PENABLE     <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (TIMEOUT != 0) begin
                        if (wait_cnt_r == WAIT_LAST) begin
                            rsp_rdata   <= '0;
                            rsp_error   <= 1'b1;
                            rsp_timeout <= 1'b1;
                            rsp_valid   <= 1'b1;
                            sel_enable  <= 1'b0;
                            PENABLE     <= 1'b0;
                            state_r     <= ST_IDLE;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + 16'd1;
                        end
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                end
                default: begin
                    sel_enable <= 1'b0;
                    PENABLE    <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed self-checking bench for apb_master_ctrl; inputs driven and outputs
// sampled on the falling clock edge.
module tb_apb_master_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          CLK, RST;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_error, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [2:0]    sel_index;
    logic          sel_enable;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          PENABLE;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;

    int checks   = 0;
    int failures = 0;

    apb_master_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .rsp_timeout(rsp_timeout), .sel_index(sel_index), .sel_enable(sel_enable),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        checks++;
        if ({rsp_valid, rsp_error, rsp_timeout, sel_enable, PENABLE, PWRITE} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000",
                {rsp_valid, rsp_error, rsp_timeout, sel_enable, PENABLE, PWRITE});
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
        end
        checks++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0 || sel_index !== 3'd0) begin
            failures++; $display("FAIL reset_data got=%h/%h/%h/%0d exp=0", PADDR, PWDATA, rsp_rdata, sel_index);
        end
        RST = 1'b0;
    endtask

    task automatic test_zero_wait_write();
        PRDATA = 32'hFFFF_FFFF; PREADY = 1'b1; PSLVERR = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h8000_0010; cmd_wdata = 32'hDEAD_BEEF;
        tick();
        cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        checks++;
        if (sel_enable !== 1'b1 || PENABLE !== 1'b0 || cmd_ready !== 1'b0) begin
            failures++; $display("FAIL wr_setup_ctrl got=%b%b%b exp=100", sel_enable, PENABLE, cmd_ready);
        end
        checks++;
        if (sel_index !== 3'b100 || PADDR !== 32'h8000_0010 || PWDATA !== 32'hDEAD_BEEF || PWRITE !== 1'b1) begin
            failures++; $display("FAIL wr_setup_bus got=%b %h %h %b exp=100 80000010 deadbeef 1",
                sel_index, PADDR, PWDATA, PWRITE);
        end
        tick();
        checks++;
        if (sel_enable !== 1'b1 || PENABLE !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL wr_access_ctrl got=%b%b%b exp=110", sel_enable, PENABLE, rsp_valid);
        end
        checks++;
        if (PADDR !== 32'h8000_0010 || PWDATA !== 32'hDEAD_BEEF || sel_index !== 3'b100) begin
            failures++; $display("FAIL wr_access_bus got=%h %h %b exp=80000010 deadbeef 100", PADDR, PWDATA, sel_index);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL wr_rsp got=%b%b%b %h exp=100 00000000", rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
        end
        checks++;
        if (sel_enable !== 1'b0 || PENABLE !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL wr_rsp_ctrl got=%b%b%b exp=001", sel_enable, PENABLE, cmd_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || PADDR !== 32'h8000_0010) begin
            failures++; $display("FAIL wr_after got=%b %h exp=0 80000010", rsp_valid, PADDR);
        end
    endtask

    task automatic test_wait_read();
        logic exp_v;
        PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h2000_0004; cmd_wdata = 32'h0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            cmd_valid = 1'b0;
            exp_v = (i == 6);
            checks++;
            if (rsp_valid !== exp_v) begin
                failures++; $display("FAIL rd_wait_rsp_valid cyc=%0d got=%b exp=%b", i, rsp_valid, exp_v);
            end
            if (i == 1) begin
                checks++;
                if (sel_index !== 3'b001 || PENABLE !== 1'b0 || PWRITE !== 1'b0) begin
                    failures++; $display("FAIL rd_wait_setup got=%b %b %b exp=001 0 0", sel_index, PENABLE, PWRITE);
                end
            end else if (i == 5) begin
                checks++;
                if (PENABLE !== 1'b1 || PADDR !== 32'h2000_0004) begin
                    failures++; $display("FAIL rd_wait_access got=%b %h exp=1 20000004", PENABLE, PADDR);
                end
                PREADY = 1'b1; PRDATA = 32'h1234_5678;
            end
        end
        checks++;
        if (rsp_rdata !== 32'h1234_5678 || rsp_error !== 1'b0 || rsp_timeout !== 1'b0) begin
            failures++; $display("FAIL rd_wait_data got=%h %b%b exp=12345678 00", rsp_rdata, rsp_error, rsp_timeout);
        end
        PREADY = 1'b0;
    endtask

    task automatic test_slave_error();
        // PSLVERR asserted only during SETUP must not be reported.
        PRDATA = 32'hCAFE_0001; PREADY = 1'b1; PSLVERR = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'hE000_0000;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || PENABLE !== 1'b0 || sel_index !== 3'b111) begin
            failures++; $display("FAIL err_setup got=%b %b %b exp=0 0 111", rsp_valid, PENABLE, sel_index);
        end
        PSLVERR = 1'b0;
        tick(); tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'hCAFE_0001) begin
            failures++; $display("FAIL err_setup_ignored got=%b%b %h exp=10 cafe0001", rsp_valid, rsp_error, rsp_rdata);
        end
        PSLVERR = 1'b1; PRDATA = 32'hCAFE_0002;
        cmd_valid = 1'b1;
        tick(); cmd_valid = 1'b0;
        tick(); tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_timeout !== 1'b0) begin
            failures++; $display("FAIL err_access got=%b%b%b exp=110", rsp_valid, rsp_error, rsp_timeout);
        end
        checks++;
        if (rsp_rdata !== 32'hCAFE_0002) begin
            failures++; $display("FAIL err_rdata got=%h exp=cafe0002", rsp_rdata);
        end
        PSLVERR = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        PRDATA = 32'hA5A5_A5A5; PREADY = 1'b0; PSLVERR = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0000;
        tick(); cmd_valid = 1'b0;
        tick();
        n = 0;
        while (PENABLE === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16) begin
            failures++; $display("FAIL to_access_len got=%0d exp=16", n);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL to_rsp got=%b%b%b %h exp=111 00000000", rsp_valid, rsp_error, rsp_timeout, rsp_rdata);
        end
        checks++;
        if (sel_enable !== 1'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL to_sel_en got=%b%b exp=01", sel_enable, cmd_ready);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b1) begin
            failures++; $display("FAIL to_hold got=%b%b exp=01", rsp_valid, rsp_timeout);
        end
    endtask

    task automatic test_back_to_back();
        PRDATA = 32'h0BAD_F00D; PREADY = 1'b1; PSLVERR = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h6000_0000; cmd_wdata = 32'h1111_1111;
        tick();
        checks++;
        if (PADDR !== 32'h6000_0000 || sel_index !== 3'b011) begin
            failures++; $display("FAIL b2b_setup1 got=%h %b exp=60000000 011", PADDR, sel_index);
        end
        cmd_write = 1'b0; cmd_addr = 32'hA000_0008; cmd_wdata = 32'h0;
        tick();
        checks++;
        if (PADDR !== 32'h6000_0000 || cmd_ready !== 1'b0 || PENABLE !== 1'b1) begin
            failures++; $display("FAIL b2b_access1 got=%h %b %b exp=60000000 0 1", PADDR, cmd_ready, PENABLE);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || cmd_ready !== 1'b1 || sel_enable !== 1'b0 || rsp_rdata !== 32'h0) begin
            failures++; $display("FAIL b2b_rsp1 got=%b%b%b %h exp=110 00000000", rsp_valid, cmd_ready, sel_enable, rsp_rdata);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (sel_enable !== 1'b1 || PADDR !== 32'hA000_0008 || sel_index !== 3'b101 || PWRITE !== 1'b0) begin
            failures++; $display("FAIL b2b_setup2 got=%b %h %b %b exp=1 a0000008 101 0", sel_enable, PADDR, sel_index, PWRITE);
        end
        tick(); tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D) begin
            failures++; $display("FAIL b2b_rsp2 got=%b %h exp=1 0badf00d", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_mid_reset();
        PREADY = 1'b0; PSLVERR = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC000_0000; cmd_wdata = 32'h5555_5555;
        tick(); cmd_valid = 1'b0;
        tick();
        checks++;
        if (PENABLE !== 1'b1) begin
            failures++; $display("FAIL mr_in_access got=%b exp=1", PENABLE);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0; PREADY = 1'b1;
        checks++;
        if ({rsp_valid, rsp_error, rsp_timeout, sel_enable, PENABLE, PWRITE} !== 6'b0 || cmd_ready !== 1'b1) begin
            failures++; $display("FAIL mr_ctrl got=%b %b exp=000000 1",
                {rsp_valid, rsp_error, rsp_timeout, sel_enable, PENABLE, PWRITE}, cmd_ready);
        end
        checks++;
        if (PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0 || sel_index !== 3'd0) begin
            failures++; $display("FAIL mr_data got=%h %h %h %b exp=0", PADDR, PWDATA, rsp_rdata, sel_index);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0 || sel_enable !== 1'b0) begin
                failures++; $display("FAIL mr_no_rsp cyc=%0d got=%b%b exp=00", i, rsp_valid, sel_enable);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
